// File: rtl/lcd_sequencer_pkg.sv
// Shared definitions for the LCD sequencer: state encoding, transfer kinds,
// HD44780-style command bytes and the power-up command list.
package lcd_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_POWERUP = 3'd0,
      ST_INIT    = 3'd1,
      ST_SEND    = 3'd2,
      ST_WAIT    = 3'd3,
      ST_DELAY   = 3'd4,
      ST_IDLE    = 3'd5
   } state_t;

   // What the transfer in flight was, so WAIT/DELAY know where to go next.
   typedef enum logic [1:0] {
      XF_INIT   = 2'd0,
      XF_DATA   = 2'd1,
      XF_CURSOR = 2'd2,
      XF_CLEAR  = 2'd3
   } xfer_t;

   localparam logic [7:0] CMD_FUNC_SET   = 8'h28;
   localparam logic [7:0] CMD_DISPLAY_ON = 8'h0C;
   localparam logic [7:0] CMD_CLEAR      = 8'h01;
   localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;
   localparam logic [7:0] CMD_LINE1      = 8'h80;
   localparam logic [7:0] CMD_LINE2      = 8'hC0;

   localparam int         LINE_LEN  = 16;
   localparam logic [1:0] INIT_LAST = 2'd3;

   // Power-up command list, indexed by the init step.
   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    return CMD_FUNC_SET;
         2'd1:    return CMD_DISPLAY_ON;
         2'd2:    return CMD_CLEAR;
         default: return CMD_ENTRY_MODE;
      endcase
   endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Saturating up-counter used for both the power-up wait and the post-clear
// wait. expired is high during the last cycle of a limit-cycle window.
module lcd_delay_counter #(
   parameter int WIDTH = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             count_en,
   input  logic [WIDTH-1:0] limit,
   output logic             expired
);

   logic [WIDTH-1:0] count_reg;
   logic [WIDTH:0]   count_plus_one;

   assign count_plus_one = {1'b0, count_reg} + {{WIDTH{1'b0}}, 1'b1};
   assign expired        = (count_plus_one >= {1'b0, limit});

   // Restart from zero on load, otherwise count up and hold once expired.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= '0;
      end else if (count_en && !expired) begin
         count_reg <= count_plus_one[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/lcd_sequencer.sv
// Drives an lcd_controller: runs the power-up command list, then writes
// characters, moves the cursor at line ends and services clear requests.
module lcd_sequencer
   import lcd_sequencer_pkg::*;
#(
   parameter int CLK_PERIOD_NS  = 20,
   parameter int POWERUP_CYCLES = 750000,
   parameter int CLEAR_CYCLES   = 82000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] char_data,
   input  logic       char_valid,
   output logic       char_ready,
   input  logic       clear_req,
   output logic       init_done,
   output logic       ctrl_rs,
   output logic [7:0] ctrl_data,
   output logic       ctrl_strobe,
   input  logic       ctrl_done,
   output logic [7:0] period_clk_ns
);

   localparam int MAX_DELAY = (POWERUP_CYCLES > CLEAR_CYCLES) ? POWERUP_CYCLES : CLEAR_CYCLES;
   localparam int CNT_W     = (MAX_DELAY < 1) ? 1 : $clog2(MAX_DELAY + 1);
   localparam logic [CNT_W-1:0] POWERUP_LIMIT = CNT_W'(POWERUP_CYCLES);
   localparam logic [CNT_W-1:0] CLEAR_LIMIT   = CNT_W'(CLEAR_CYCLES);
   localparam logic [4:0]       LINE2_COL     = 5'(LINE_LEN);

   state_t     state_reg, state_next;
   xfer_t      xfer_reg, xfer_next;
   logic [1:0] init_idx_reg, init_idx_next;
   logic [4:0] col_reg, col_next;
   logic       init_done_reg, init_done_next;
   logic       rs_reg, rs_next;
   logic [7:0] data_reg, data_next;

   logic [4:0]       col_inc;
   logic             delay_active;
   logic             delay_expired;
   logic [CNT_W-1:0] delay_limit;

   // col is 5 bits, so the write that would make it 32 wraps it to 0 here.
   assign col_inc      = col_reg + 5'd1;
   assign delay_active = (state_reg == ST_POWERUP) || (state_reg == ST_DELAY);
   assign delay_limit  = (state_reg == ST_POWERUP) ? POWERUP_LIMIT : CLEAR_LIMIT;

   lcd_delay_counter #(.WIDTH(CNT_W)) u_delay (
      .clk      (clk),
      .rst      (rst),
      .load     (!delay_active),
      .count_en (delay_active),
      .limit    (delay_limit),
      .expired  (delay_expired)
   );

   assign char_ready    = (state_reg == ST_IDLE) && !clear_req;
   assign ctrl_strobe   = (state_reg == ST_SEND);
   assign ctrl_rs       = rs_reg;
   assign ctrl_data     = data_reg;
   assign init_done     = init_done_reg;
   assign period_clk_ns = 8'(CLK_PERIOD_NS);

   // State and transfer registers; reset aborts anything in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= ST_POWERUP;
         xfer_reg      <= XF_INIT;
         init_idx_reg  <= 2'd0;
         col_reg       <= 5'd0;
         init_done_reg <= 1'b0;
         rs_reg        <= 1'b0;
         data_reg      <= 8'h00;
      end else begin
         state_reg     <= state_next;
         xfer_reg      <= xfer_next;
         init_idx_reg  <= init_idx_next;
         col_reg       <= col_next;
         init_done_reg <= init_done_next;
         rs_reg        <= rs_next;
         data_reg      <= data_next;
      end
   end

   // Next-state logic; rs/data only change when a new transfer is loaded,
   // so they stay put from SEND through the ctrl_done cycle.
   always_comb begin
      state_next     = state_reg;
      xfer_next      = xfer_reg;
      init_idx_next  = init_idx_reg;
      col_next       = col_reg;
      init_done_next = init_done_reg;
      rs_next        = rs_reg;
      data_next      = data_reg;
      unique case (state_reg)
         ST_POWERUP: begin
            if (delay_expired) begin
               state_next    = ST_INIT;
               init_idx_next = 2'd0;
            end
         end
         ST_INIT: begin
            rs_next    = 1'b0;
            data_next  = init_cmd(init_idx_reg);
            xfer_next  = XF_INIT;
            state_next = ST_SEND;
         end
         ST_SEND: begin
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (ctrl_done) begin
               case (xfer_reg)
                  XF_INIT: begin
                     if (data_reg == CMD_CLEAR) begin
                        state_next = ST_DELAY;
                     end else if (init_idx_reg == INIT_LAST) begin
                        init_done_next = 1'b1;
                        col_next       = 5'd0;
                        state_next     = ST_IDLE;
                     end else begin
                        init_idx_next = init_idx_reg + 2'd1;
                        state_next    = ST_INIT;
                     end
                  end
                  XF_DATA: begin
                     col_next   = col_inc;
                     state_next = ST_IDLE;
                     if (col_inc == LINE2_COL) begin
                        rs_next    = 1'b0;
                        data_next  = CMD_LINE2;
                        xfer_next  = XF_CURSOR;
                        state_next = ST_SEND;
                     end else if (col_inc == 5'd0) begin
                        rs_next    = 1'b0;
                        data_next  = CMD_LINE1;
                        xfer_next  = XF_CURSOR;
                        state_next = ST_SEND;
                     end
                  end
                  XF_CURSOR: state_next = ST_IDLE;
                  default:   state_next = ST_DELAY;
               endcase
            end
         end
         ST_DELAY: begin
            if (delay_expired) begin
               if (xfer_reg == XF_INIT) begin
                  init_idx_next = init_idx_reg + 2'd1;
                  state_next    = ST_INIT;
               end else begin
                  col_next   = 5'd0;
                  state_next = ST_IDLE;
               end
            end
         end
         ST_IDLE: begin
            if (clear_req) begin
               rs_next    = 1'b0;
               data_next  = CMD_CLEAR;
               xfer_next  = XF_CLEAR;
               state_next = ST_SEND;
            end else if (char_valid) begin
               rs_next    = 1'b1;
               data_next  = char_data;
               xfer_next  = XF_DATA;
               state_next = ST_SEND;
            end
         end
         default: state_next = ST_POWERUP;
      endcase
   end

endmodule

// File: tb/tb_lcd_sequencer.sv
// Bench for lcd_sequencer with a 3-cycle controller model and a
// transaction-level model of the expected strobe stream.
module tb_lcd_sequencer;

   localparam int P = 10;
   localparam int C = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] char_data = 8'h00;
   logic       char_valid = 1'b0;
   logic       char_ready;
   logic       clear_req = 1'b0;
   logic       init_done;
   logic       ctrl_rs;
   logic [7:0] ctrl_data;
   logic       ctrl_strobe;
   logic       ctrl_done;
   logic [7:0] period_clk_ns;

   lcd_sequencer #(.CLK_PERIOD_NS(20), .POWERUP_CYCLES(P), .CLEAR_CYCLES(C)) dut (
      .clk(clk), .rst(rst), .char_data(char_data), .char_valid(char_valid),
      .char_ready(char_ready), .clear_req(clear_req), .init_done(init_done),
      .ctrl_rs(ctrl_rs), .ctrl_data(ctrl_data), .ctrl_strobe(ctrl_strobe),
      .ctrl_done(ctrl_done), .period_clk_ns(period_clk_ns)
   );

   always #5 clk = ~clk;

   // Controller model: ctrl_done is high in the third cycle after a strobe.
   logic [1:0] ctrl_pipe;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_pipe <= 2'b00;
         ctrl_done <= 1'b0;
      end else begin
         ctrl_pipe <= {ctrl_pipe[0], ctrl_strobe};
         ctrl_done <= ctrl_pipe[1];
      end
   end

   // Monitor: logs strobes, done pulses, accepts and the init_done rise.
   int         cyc = 0;
   logic [8:0] strobe_q[$];
   int         strobe_cyc_q[$];
   int         done_cyc_q[$];
   int         accept_cnt = 0;
   int         init_rise_cyc = 0;
   int         init_seen = 0;
   always @(negedge clk) begin
      cyc++;
      if (ctrl_strobe === 1'b1) begin
         strobe_q.push_back({ctrl_rs, ctrl_data});
         strobe_cyc_q.push_back(cyc);
      end
      if (ctrl_done === 1'b1) done_cyc_q.push_back(cyc);
      if (char_valid === 1'b1 && char_ready === 1'b1) accept_cnt++;
      if (rst === 1'b0) init_seen = 0;
      else if (init_done === 1'b1 && init_seen == 0) begin
         init_seen     = 1;
         init_rise_cyc = cyc;
      end
   end

   // Reference model: expected {rs,data} stream derived from cursor column.
   logic [8:0] exp_q[$];
   int         model_col = 0;
   int         n_checks = 0;
   int         n_pass = 0;

   function automatic void model_init();
      exp_q.delete();
      exp_q.push_back({1'b0, 8'h28});
      exp_q.push_back({1'b0, 8'h0C});
      exp_q.push_back({1'b0, 8'h01});
      exp_q.push_back({1'b0, 8'h06});
      model_col = 0;
   endfunction

   function automatic void model_write(input logic [7:0] ch);
      exp_q.push_back({1'b1, ch});
      model_col++;
      if (model_col == 16) exp_q.push_back({1'b0, 8'hC0});
      else if (model_col == 32) begin
         model_col = 0;
         exp_q.push_back({1'b0, 8'h80});
      end
   endfunction

   function automatic void clear_logs();
      strobe_q.delete();
      strobe_cyc_q.delete();
      done_cyc_q.delete();
      exp_q.delete();
   endfunction

   task automatic tick_drive();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_sample();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_idle(output int ok);
      int guard = 0;
      tick_sample();
      while (char_ready !== 1'b1 && guard < 100) begin
         tick_sample();
         guard++;
      end
      ok = (guard < 100);
      tick_drive();
   endtask

   task automatic wait_init(output int ok);
      int guard = 0;
      while (init_done !== 1'b1 && guard < 300) begin
         tick_sample();
         guard++;
      end
      ok = (guard < 300);
   endtask

   // Streams n random printable chars with random valid gaps.
   task automatic send_chars(input int n, output int ok);
      int         sent = 0;
      int         guard = 0;
      logic [7:0] cur;
      cur = 8'($urandom_range(32, 126));
      while (sent < n && guard < n * 30 + 50) begin
         char_data  = cur;
         char_valid = ($urandom_range(0, 3) != 0);
         tick_sample();
         guard++;
         if (char_valid === 1'b1 && char_ready === 1'b1) begin
            model_write(cur);
            sent++;
            cur = 8'($urandom_range(32, 126));
         end
         tick_drive();
      end
      char_valid = 1'b0;
      ok = (sent == n);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #3 rst = 1'b0;
      #1;
      n_checks++;
      if (ctrl_strobe !== 1'b0) $display("FAIL reset_strobe: got %b expected 0", ctrl_strobe); else n_pass++;
      n_checks++;
      if (ctrl_rs !== 1'b0) $display("FAIL reset_rs: got %b expected 0", ctrl_rs); else n_pass++;
      n_checks++;
      if (ctrl_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", ctrl_data); else n_pass++;
      n_checks++;
      if (init_done !== 1'b0) $display("FAIL reset_init_done: got %b expected 0", init_done); else n_pass++;
      n_checks++;
      if (char_ready !== 1'b0) $display("FAIL reset_char_ready: got %b expected 0", char_ready); else n_pass++;
      n_checks++;
      if (period_clk_ns !== 8'd20) $display("FAIL reset_period: got %0d expected 20", period_clk_ns); else n_pass++;
      $display("reset: outputs checked while rst low");
   endtask

   task automatic test_powerup_init();
      int rel;
      int ok;
      repeat (3) tick_drive();
      clear_logs();
      rel = cyc;
      rst = 1'b1;
      wait_init(ok);
      model_init();
      n_checks++;
      if (ok == 0) $display("FAIL init_timeout: init_done got %b expected 1", init_done); else n_pass++;
      n_checks++;
      if (strobe_q.size() != exp_q.size())
         $display("FAIL init_count: got %0d strobes expected %0d", strobe_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++;
         if (i >= strobe_q.size()) $display("FAIL init_strobe[%0d]: got none expected %h", i, exp_q[i]);
         else if (strobe_q[i] !== exp_q[i]) $display("FAIL init_strobe[%0d]: got %h expected %h", i, strobe_q[i], exp_q[i]);
         else n_pass++;
         if (i < strobe_q.size()) $display("init: strobe rs=%b data=%h", strobe_q[i][8], strobe_q[i][7:0]);
      end
      n_checks++;
      if (strobe_cyc_q.size() >= 4 && done_cyc_q.size() >= 4) begin
         n_pass++;
         n_checks++;
         if (strobe_cyc_q[0] - rel <= P)
            $display("FAIL powerup_wait: got first strobe %0d cycles after release expected more than %0d", strobe_cyc_q[0] - rel, P);
         else n_pass++;
         n_checks++;
         if (strobe_cyc_q[3] - done_cyc_q[2] <= C)
            $display("FAIL clear_delay: got %0d cycles from 0x01 done to next strobe expected more than %0d", strobe_cyc_q[3] - done_cyc_q[2], C);
         else n_pass++;
         n_checks++;
         if (init_rise_cyc <= done_cyc_q[3])
            $display("FAIL init_done_rise: got cycle %0d expected after done cycle %0d", init_rise_cyc, done_cyc_q[3]);
         else n_pass++;
      end else begin
         $display("FAIL init_events: got %0d strobes %0d dones expected 4 of each", strobe_cyc_q.size(), done_cyc_q.size());
      end
   endtask

   task automatic test_single_char();
      int acc0;
      int nd;
      int guard = 0;
      int ready_low = 1;
      int ok;
      tick_drive();
      wait_idle(ok);
      clear_logs();
      acc0       = accept_cnt;
      char_data  = 8'h41;
      char_valid = 1'b1;
      tick_sample();
      n_checks++;
      if (char_ready !== 1'b1) $display("FAIL char_ready_idle: got %b expected 1", char_ready); else n_pass++;
      model_write(8'h41);
      nd = done_cyc_q.size();
      while (done_cyc_q.size() == nd && guard < 50) begin
         tick_sample();
         guard++;
         if (char_ready !== 1'b0) ready_low = 0;
      end
      tick_drive();
      char_valid = 1'b0;
      repeat (3) tick_drive();
      n_checks++;
      if (guard >= 50) $display("FAIL char_done_timeout: got no ctrl_done within %0d cycles expected one", guard); else n_pass++;
      n_checks++;
      if (ready_low == 0) $display("FAIL char_ready_busy: got high before done expected low"); else n_pass++;
      n_checks++;
      if (accept_cnt - acc0 != 1) $display("FAIL char_accepts: got %0d expected 1", accept_cnt - acc0); else n_pass++;
      n_checks++;
      if (strobe_q.size() != 1 || strobe_q[0] !== exp_q[0])
         $display("FAIL char_strobe: got %0d strobes first %h expected 1 strobe %h", strobe_q.size(),
                  (strobe_q.size() > 0) ? strobe_q[0] : 9'h0, exp_q[0]);
      else n_pass++;
      $display("char: sent 0x41, %0d strobe(s) seen", strobe_q.size());
   endtask

   task automatic test_line_wrap();
      int ok1;
      int ok2;
      int ok3;
      clear_logs();
      send_chars(31, ok1);
      send_chars(16, ok2);
      wait_idle(ok3);
      n_checks++;
      if (ok1 == 0 || ok2 == 0 || ok3 == 0) $display("FAIL wrap_progress: got stall (%0d %0d %0d) expected all 1", ok1, ok2, ok3); else n_pass++;
      n_checks++;
      if (strobe_q.size() != exp_q.size())
         $display("FAIL wrap_count: got %0d strobes expected %0d", strobe_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++;
         if (i >= strobe_q.size()) $display("FAIL wrap_strobe[%0d]: got none expected %h", i, exp_q[i]);
         else if (strobe_q[i] !== exp_q[i]) $display("FAIL wrap_strobe[%0d]: got %h expected %h", i, strobe_q[i], exp_q[i]);
         else n_pass++;
         if (i < strobe_q.size()) $display("wrap: strobe %0d rs=%b data=%h", i, strobe_q[i][8], strobe_q[i][7:0]);
      end
   endtask

   task automatic test_clear_collision();
      logic [7:0] x;
      int acc0;
      int guard = 0;
      int ok1;
      int ok2;
      clear_logs();
      x          = 8'($urandom_range(32, 126));
      acc0       = accept_cnt;
      clear_req  = 1'b1;
      char_valid = 1'b1;
      char_data  = x;
      tick_sample();
      n_checks++;
      if (char_ready !== 1'b0) $display("FAIL clear_wins: got char_ready %b expected 0", char_ready); else n_pass++;
      exp_q.push_back({1'b0, 8'h01});
      model_col = 0;
      tick_drive();
      clear_req = 1'b0;
      while (char_ready !== 1'b1 && guard < 60) begin
         tick_sample();
         guard++;
      end
      model_write(x);
      tick_drive();
      char_valid = 1'b0;
      tick_drive();
      clear_req = 1'b1;
      tick_drive();
      clear_req = 1'b0;
      n_checks++;
      if (guard >= 60 || accept_cnt - acc0 != 1)
         $display("FAIL clear_accepts: got %0d accepts after %0d cycles expected 1", accept_cnt - acc0, guard);
      else n_pass++;
      n_checks++;
      if (strobe_cyc_q.size() >= 2 && done_cyc_q.size() >= 1 && strobe_cyc_q[1] - done_cyc_q[0] > C) n_pass++;
      else $display("FAIL clear_gap: got %0d strobes %0d dones (gap too short or missing) expected gap above %0d",
                    strobe_cyc_q.size(), done_cyc_q.size(), C);
      send_chars(15, ok1);
      wait_idle(ok2);
      n_checks++;
      if (ok1 == 0 || ok2 == 0) $display("FAIL clear_progress: got stall (%0d %0d) expected all 1", ok1, ok2); else n_pass++;
      n_checks++;
      if (strobe_q.size() != exp_q.size())
         $display("FAIL clear_count: got %0d strobes expected %0d", strobe_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++;
         if (i >= strobe_q.size()) $display("FAIL clear_strobe[%0d]: got none expected %h", i, exp_q[i]);
         else if (strobe_q[i] !== exp_q[i]) $display("FAIL clear_strobe[%0d]: got %h expected %h", i, strobe_q[i], exp_q[i]);
         else n_pass++;
      end
      $display("clear: clear+char collision, %0d strobes seen", strobe_q.size());
   endtask

   task automatic test_reset_in_wait();
      int rel;
      int ok;
      clear_logs();
      char_data  = 8'($urandom_range(32, 126));
      char_valid = 1'b1;
      tick_sample();
      tick_drive();
      char_valid = 1'b0;
      tick_drive();
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if (ctrl_strobe !== 1'b0 || ctrl_rs !== 1'b0 || ctrl_data !== 8'h00)
         $display("FAIL wait_reset_ctrl: got strobe=%b rs=%b data=%h expected 0 0 00", ctrl_strobe, ctrl_rs, ctrl_data);
      else n_pass++;
      n_checks++;
      if (init_done !== 1'b0 || char_ready !== 1'b0)
         $display("FAIL wait_reset_status: got init_done=%b char_ready=%b expected 0 0", init_done, char_ready);
      else n_pass++;
      repeat (2) tick_drive();
      clear_logs();
      rel = cyc;
      rst = 1'b1;
      wait_init(ok);
      model_init();
      n_checks++;
      if (ok == 0) $display("FAIL reinit_timeout: init_done got %b expected 1", init_done); else n_pass++;
      n_checks++;
      if (strobe_q.size() != exp_q.size())
         $display("FAIL reinit_count: got %0d strobes expected %0d", strobe_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++;
         if (i >= strobe_q.size()) $display("FAIL reinit_strobe[%0d]: got none expected %h", i, exp_q[i]);
         else if (strobe_q[i] !== exp_q[i]) $display("FAIL reinit_strobe[%0d]: got %h expected %h", i, strobe_q[i], exp_q[i]);
         else n_pass++;
      end
      n_checks++;
      if (strobe_cyc_q.size() > 0 && strobe_cyc_q[0] - rel > P) n_pass++;
      else $display("FAIL reinit_powerup: got %0d strobes, first too early or missing, expected first after %0d cycles",
                    strobe_cyc_q.size(), P);
      $display("reset_in_wait: init sequence repeated with %0d strobes", strobe_q.size());
   endtask

   initial begin
      test_reset();
      test_powerup_init();
      test_single_char();
      test_line_wrap();
      test_clear_collision();
      test_reset_in_wait();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by 200000 ns expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/lcd_sequencer.md
LCD_SEQUENCER -- requirements
Module: lcd_sequencer

Interface
REQ-001 Parameter CLK_PERIOD_NS, default 20, clock period in ns, driven constant on period_clk_ns.
REQ-002 Parameter POWERUP_CYCLES, default 750000, post-reset wait before the first command (15 ms at 50 MHz).
REQ-003 Parameter CLEAR_CYCLES, default 82000, extra wait after a clear-display command (1.64 ms at 50 MHz).
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 char_data  in  8  ASCII character to display.
REQ-007 char_valid  in  1  char_data is valid.
REQ-008 char_ready  out  1  sequencer accepts char_data this cycle.
REQ-009 clear_req  in  1  request to clear the display and home the cursor, sampled in IDLE.
REQ-010 init_done  out  1  power-up init is complete; level.
REQ-011 ctrl_rs  out  1  register select to lcd_controller (0 command, 1 data).
REQ-012 ctrl_data  out  8  byte to lcd_controller.
REQ-013 ctrl_strobe  out  1  one-cycle start pulse to lcd_controller.
REQ-014 ctrl_done  in  1  one-cycle pulse from lcd_controller when the transfer is finished.
REQ-015 period_clk_ns  out  8  CLK_PERIOD_NS[7:0] to lcd_controller.

Function
REQ-016 States: POWERUP, INIT, SEND, WAIT, DELAY, IDLE.
REQ-017 POWERUP: count POWERUP_CYCLES clocks, then go to INIT with init index 0.
REQ-018 INIT issues, in order, rs=0 bytes 0x28, 0x0C, 0x01, 0x06.
- Each byte goes through SEND/WAIT.
- After 0x01, stay in DELAY for CLEAR_CYCLES clocks.
- After 0x06, set init_done=1, col=0, go to IDLE.
REQ-019 SEND lasts exactly one cycle.
- ctrl_strobe=1 for that cycle only.
- ctrl_rs and ctrl_data are registered.
- ctrl_rs and ctrl_data hold stable from SEND until the ctrl_done cycle.
REQ-020 WAIT holds until ctrl_done=1.
- ctrl_done outside WAIT is ignored.
- No timeout.
REQ-021 char_ready = (state==IDLE) && !clear_req; combinational from the state register and clear_req.
REQ-022 Char accept: char_valid && char_ready.
- Latch the byte and send it with rs=1.
- The first strobe occurs in the cycle after acceptance.
REQ-023 col is 5 bits, range 0..31, incremented on the ctrl_done of each data write.
- New col==16: send rs=0 0xC0 (line 2) before returning to IDLE.
- New col==32: set col=0 and send rs=0 0x80 (line 1).
REQ-024 clear_req in IDLE sends rs=0 0x01, then DELAY for CLEAR_CYCLES, then sets col=0 and returns to IDLE.
REQ-025 clear_req and char_valid in the same IDLE cycle: clear wins and the char is not accepted.
REQ-026 clear_req and char_valid are ignored outside IDLE; no queuing.
REQ-027 Delay counters are wide enough for max(POWERUP_CYCLES, CLEAR_CYCLES), with no wrap.

Reset
REQ-028 On rst=0, asynchronously:
- state=POWERUP, counters=0, col=0, init index=0.
- init_done=0, ctrl_strobe=0, ctrl_rs=0, ctrl_data=0x00, char_ready=0.
REQ-029 Assertion mid-operation aborts any transfer; after release the full power-up sequence restarts.
REQ-030 period_clk_ns equals CLK_PERIOD_NS[7:0] at all times, reset included.

Structure
REQ-031 Shared package holds:
- State encoding.
- Command constants: 0x28, 0x0C, 0x01, 0x06, 0x80, 0xC0.
- Line length 16.
REQ-032 One sub-module, lcd_delay_counter (load/count/expired), is reused for both the POWERUP and DELAY waits.

Verification
All scenarios use POWERUP_CYCLES=10, CLEAR_CYCLES=5 and a controller model that pulses ctrl_done 3 cycles after each strobe.
REQ-033 Release reset:
- No strobe for 10 cycles.
- Strobes carry 0x28, 0x0C, 0x01, 0x06 (rs=0).
- At least 5 idle cycles follow the 0x01 done.
- init_done rises after the 0x06 done.
REQ-034 After init, send 'A' (0x41) with valid held:
- Exactly one accept.
- One strobe with rs=1, data 0x41.
- char_ready stays low until after its done.
REQ-035 Write 16 chars: the 16th data done is followed by a strobe with rs=0 0xC0 before char_ready returns.
REQ-036 Write 32 chars: the 32nd is followed by rs=0 0x80, and the next char lands at col 0.
REQ-037 clear_req and char_valid together in IDLE:
- No accept.
- rs=0 0x01 strobe, then 5-cycle delay.
- col=0.
- The char is accepted afterwards.
REQ-038 Assert rst during WAIT:
- Outputs go to reset values immediately.
- After release the full init sequence repeats.
